// File: rtl/fifo_dpram.sv
// First-word-fall-through stream FIFO backed by a registered-read dual-port RAM.
// Latency: push at edge E -> out_valid after edge E+2 (RAM read plus prefetch capture, no bypass).
// Backpressure: in_ready drops only at count==DATA_DEPTH; out_data/out_valid hold while out_ready is low.

// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the previous contents.
module dpram_rw #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rd_en,
  input  logic [$clog2(DATA_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(DATA_DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  // Write port: store the word on the enabling edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: output register only moves when a read is requested.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

module fifo_dpram #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(DATA_DEPTH):0]   count
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_DEPTH);

  // Pointers and occupancy.
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  // Words written into the RAM whose read has not yet been issued.
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  // A read was issued last cycle; rd_data carries it this cycle.
  logic                  rd_pend_q, rd_pend_d;

  // Two-entry prefetch buffer; buf0 is the head presented on out_data.
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;

  // RAM interface.
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  push;
  logic                  pop;
  logic [1:0]            buf_after;

  assign in_ready  = rst_n && (count_q != FULL_CNT);
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Buffer slots committed once this cycle's pop leaves and the pending read lands.
  // Counting the pop here is what allows one read per cycle in steady streaming.
  assign buf_after = buf_cnt_q - {1'b0, pop} + {1'b0, rd_pend_q};

  // Only words written on an earlier edge are read, so the read never aliases
  // the address being written in the same cycle.
  assign rd_en = rst_n && (ram_cnt_q != '0) && (buf_after < 2'd2);
  assign wr_en = push;

  dpram_rw #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data)
  );

  // Pointer, occupancy and read-tracking next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ram_cnt_d = ram_cnt_q;
    rd_pend_d = rd_en;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({push, rd_en})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Prefetch buffer next state: pop shifts the head out, the landing read fills the tail.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;

    case ({rd_pend_q, pop})
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = rd_data;
        end else begin
          buf1_d = rd_data;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = rd_data;
        end else begin
          buf0_d = rd_data;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  // Control state; reset drops everything in flight but leaves RAM contents alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      buf_cnt_q <= 2'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  // Buffer data words; their validity is tracked by buf_cnt_q alone.
  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

endmodule

// File: tb/tb_fifo_dpram.sv
module tb_fifo_dpram;

  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [8:0]    count;

  always #5 clk = ~clk;

  fifo_dpram #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model_q [$];
  bit            chk_en = 1'b0;
  int            pop_total = 0;
  bit            saw_full = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  int            first_k;
  int            last_k;
  int            nv;
  int            p0;
  int            t;
  logic [DW-1:0] first_word;
  logic [DW-1:0] basic_words [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and return just after it, ready to drive the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    t = 0;
    while ((count != 0 || out_valid) && t < 3000) begin
      step();
      t++;
    end
    chk("drain_count", 32'(count), 32'd0);
    repeat (4) step();
  endtask

  // Monitor: sampled mid-cycle, models the handshakes that commit on the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("count", 32'(count), 32'(model_q.size()));
        chk("in_ready", 32'(in_ready), 32'(rst_n && (model_q.size() != DEPTH)));
        if (model_q.size() == DEPTH) saw_full = 1'b1;
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (!rst_n) begin
          model_q.delete();
          prev_stall = 1'b0;
        end else begin
          if (model_q.size() == 0) chk("valid_when_empty", 32'(out_valid), 32'd0);
          if (out_valid && out_ready && model_q.size() != 0) begin
            chk("data", 32'(out_data), 32'(model_q.pop_front()));
            pop_total++;
          end
          if (in_valid && in_ready) model_q.push_back(in_data);
          prev_stall = out_valid && !out_ready;
          prev_data  = out_data;
        end
      end
    end
  end

  initial begin
    basic_words[0] = 8'hde;
    basic_words[1] = 8'had;
    basic_words[2] = 8'hbe;
    basic_words[3] = 8'hef;

    // Reset
    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic: four pushes on consecutive edges, consumer always ready
    out_ready = 1'b1;
    first_k = -1;
    last_k  = -1;
    nv      = 0;
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 4);
      in_data  = (k < 4) ? basic_words[k] : 8'h00;
      step();
      if (out_valid) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        nv++;
      end
    end
    in_valid = 1'b0;
    chk("basic_first_valid_edge", 32'(first_k), 32'd2);
    chk("basic_last_valid_edge", 32'(last_k), 32'd5);
    chk("basic_valid_cycles", 32'(nv), 32'd4);
    chk("basic_count_end", 32'(count), 32'd0);

    // Full: fill to capacity with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = (i % 2 != 0) ? 8'ha5 : 8'h5a;
      step();
    end
    in_data = 8'h77;
    repeat (3) begin
      step();
      chk("full_count", 32'(count), 32'd256);
      chk("full_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_reopen_in_ready", 32'(in_ready), 32'd1);
    chk("full_reopen_count", 32'(count), 32'd255);
    drain();

    // Stall: eight words held with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      if (i == 0) first_word = in_data;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_head", 32'(out_data), 32'(first_word));
      chk("stall_count", 32'(count), 32'd8);
    end
    drain();

    // Throughput and wrap: continuous streaming from empty
    out_ready = 1'b1;
    p0 = pop_total;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("tput_pops", 32'(pop_total - p0), 32'd997);
    drain();

    // Random back-pressure in alternating fill / drain phases
    for (int blk = 0; blk < 10; blk++) begin
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 99) < ((blk % 2 == 0) ? 90 : 30));
        out_ready = ($urandom_range(0, 99) < ((blk % 2 == 0) ? 30 : 90));
        in_data   = 8'($urandom);
        step();
      end
    end
    in_valid = 1'b0;
    chk("random_reached_full", 32'(saw_full), 32'd1);
    drain();

    // Reset mid-operation drops all buffered words
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 8'h10);
      step();
    end
    rst_n    = 1'b0;
    in_data  = 8'h33;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5a;
    step();
    in_valid = 1'b0;
    chk("midrst_valid_e0", 32'(out_valid), 32'd0);
    step();
    chk("midrst_valid_e1", 32'(out_valid), 32'd0);
    step();
    chk("midrst_valid_e2", 32'(out_valid), 32'd1);
    chk("midrst_data_e2", 32'(out_data), 32'h5a);
    repeat (5) step();
    chk("midrst_count_end", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
